// File: rtl/mem_data_arbiter.sv
// Shares the byte-wide data segment between the cpu MEM stage and the dbg loader.
// Each 16-bit word access becomes two byte accesses (low byte first); read bytes are
// reassembled and handed back with a one-cycle done pulse to the granted requester.
module mem_data_arbiter #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 13,
  parameter int BYTE_W = 8,
  parameter int RR     = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WIDTH-1:0]  cpu_addr,
  input  logic [WIDTH-1:0]  cpu_wd,
  output logic [WIDTH-1:0]  cpu_rd,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [WIDTH-1:0]  dbg_addr,
  input  logic [WIDTH-1:0]  dbg_wd,
  output logic [WIDTH-1:0]  dbg_rd,
  output logic              dbg_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BYTE_W-1:0] mem_wd,
  input  logic [BYTE_W-1:0] mem_rd
);

  localparam int WA_W = ADDR_W - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state;
  logic              owner;      // 0 = cpu, 1 = dbg
  logic              last_dbg;   // 1 when dbg received the most recent grant
  logic              lat_we;
  logic [WA_W-1:0]   lat_addr;
  logic [WIDTH-1:0]  lat_wd;
  logic [BYTE_W-1:0] lo_byte;
  logic [WIDTH-1:0]  cpu_rd_q;
  logic [WIDTH-1:0]  dbg_rd_q;
  logic              any_req;
  logic              grant_dbg;
  logic              resp;
  logic [WIDTH-1:0]  assembled;
  logic              unused_addr_bits;

  // Word address bits above the data segment are intentionally dropped (address wrap).
  assign unused_addr_bits = ^{cpu_addr[WIDTH-1:WA_W], dbg_addr[WIDTH-1:WA_W]};

  assign any_req = cpu_req | dbg_req;

  // Arbitration: fixed cpu priority, or on a tie the requester not granted last.
  always_comb begin
    grant_dbg = 1'b0;
    if (RR == 0) begin
      grant_dbg = ~cpu_req & dbg_req;
    end else begin
      grant_dbg = dbg_req & (~cpu_req | ~last_dbg);
    end
  end

  // Sequencer state, owner and last-grant flag; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      owner    <= 1'b0;
      last_dbg <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state    <= S_LO;
            owner    <= grant_dbg;
            last_dbg <= grant_dbg;
          end
        end
        S_LO:    state <= S_HI;
        S_HI:    state <= S_RESP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request latch at grant and low read byte capture; datapath only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && any_req) begin
      lat_we   <= grant_dbg ? dbg_we : cpu_we;
      lat_addr <= grant_dbg ? dbg_addr[WA_W-1:0] : cpu_addr[WA_W-1:0];
      lat_wd   <= grant_dbg ? dbg_wd : cpu_wd;
    end
    if (state == S_HI) begin
      lo_byte <= mem_rd;
    end
  end

  assign resp      = (state == S_RESP);
  assign assembled = {mem_rd, lo_byte};

  // Held read data per requester, updated when its load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_q <= '0;
      dbg_rd_q <= '0;
    end else if (resp && !lat_we) begin
      if (owner) dbg_rd_q <= assembled;
      else       cpu_rd_q <= assembled;
    end
  end

  // Byte-port drive: only LO/HI touch memory, everything else parks at zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    case (state)
      S_LO: begin
        mem_addr = {lat_addr, 1'b0};
        if (lat_we) begin
          mem_we = 1'b1;
          mem_wd = lat_wd[BYTE_W-1:0];
        end
      end
      S_HI: begin
        mem_addr = {lat_addr, 1'b1};
        if (lat_we) begin
          mem_we = 1'b1;
          mem_wd = lat_wd[WIDTH-1:BYTE_W];
        end
      end
      default: ;
    endcase
  end

  assign cpu_done  = resp & ~owner;
  assign dbg_done  = resp &  owner;
  assign cpu_rd    = (cpu_done && !lat_we) ? assembled : cpu_rd_q;
  assign dbg_rd    = (dbg_done && !lat_we) ? assembled : dbg_rd_q;
  assign cpu_stall = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Scoreboard bench for mem_data_arbiter: a byte memory sits on the data port, a word-level
// reference array predicts load data, and monitors check every done pulse against queues.
module tb_mem_data_arbiter;

  typedef struct {
    bit          ld;
    logic [15:0] d;
    int          lat;
    int          t0;
  } sb_item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wd, dbg_addr, dbg_wd;
  logic [15:0] cpu_rd, dbg_rd;
  logic        cpu_done, cpu_stall, dbg_done;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wd, mem_rd;

  logic        r_cpu_req, r_dbg_req;
  logic [15:0] r_cpu_rd, r_dbg_rd;
  logic        r_cpu_done, r_cpu_stall, r_dbg_done, r_mem_we;
  logic [12:0] r_mem_addr;
  logic [7:0]  r_mem_wd;
  logic [7:0]  r_mem_rd = 8'h00;
  logic [15:0] zero16 = 16'h0000;
  logic        zero1 = 1'b0;

  logic [7:0]  bmem [0:8191];
  logic [15:0] ref_mem [0:4095];
  sb_item_t    cpu_q[$], dbg_q[$];
  bit          rr_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] last_cpu_rd = 16'h0, last_dbg_rd = 16'h0;
  bit          spacing_on = 1'b0;
  int          last_cpu_done = -1;

  always #5 clk = ~clk;

  mem_data_arbiter #(.WIDTH(16), .ADDR_W(13), .BYTE_W(8), .RR(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_rd(dbg_rd), .dbg_done(dbg_done),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  mem_data_arbiter #(.WIDTH(16), .ADDR_W(13), .BYTE_W(8), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(r_cpu_req), .cpu_we(zero1), .cpu_addr(zero16), .cpu_wd(zero16),
    .cpu_rd(r_cpu_rd), .cpu_done(r_cpu_done), .cpu_stall(r_cpu_stall),
    .dbg_req(r_dbg_req), .dbg_we(zero1), .dbg_addr(zero16), .dbg_wd(zero16),
    .dbg_rd(r_dbg_rd), .dbg_done(r_dbg_done),
    .mem_we(r_mem_we), .mem_addr(r_mem_addr), .mem_wd(r_mem_wd), .mem_rd(r_mem_rd)
  );

  // Byte memory with one-cycle registered read.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) bmem[mem_addr] <= mem_wd;
    mem_rd <= bmem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive a request and push the predicted response.
  task automatic issue(input bit who, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input int lat);
    sb_item_t it;
    if (we) ref_mem[a[11:0]] = wd;
    it.ld  = !we;
    it.d   = ref_mem[a[11:0]];
    it.lat = lat;
    it.t0  = cyc;
    if (!who) begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wd = wd;
      cpu_q.push_back(it);
    end else begin
      dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wd = wd;
      dbg_q.push_back(it);
    end
  endtask

  // Drop each request once its response was seen; bounded.
  task automatic wait_all(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (cpu_q.size() == 0) cpu_req = 1'b0;
      if (dbg_q.size() == 0) dbg_req = 1'b0;
      if (!cpu_req && !dbg_req) begin
        chk("cpu_rd_hold", {16'h0, cpu_rd}, {16'h0, last_cpu_rd});
        chk("dbg_rd_hold", {16'h0, dbg_rd}, {16'h0, last_dbg_rd});
        return;
      end
    end
    checks++; failures++;
    $display("FAIL wait_all timeout actual=pending required=idle");
  endtask

  // Single access with byte-bus checks; must be called 1 time unit after a rising edge.
  task automatic access_check(input bit who, input bit we, input logic [15:0] a,
                              input logic [15:0] wd);
    logic [12:0] ba;
    ba = {a[11:0], 1'b0};
    issue(who, we, a, wd, 3);
    @(negedge clk);
    chk("idle_we", {31'h0, mem_we}, 32'h0);
    if (!who) chk("stall_t0", {31'h0, cpu_stall}, 32'h1);
    @(negedge clk);
    chk("lo_addr", {19'h0, mem_addr}, {19'h0, ba});
    chk("lo_we", {31'h0, mem_we}, {31'h0, we});
    if (we) chk("lo_wd", {24'h0, mem_wd}, {24'h0, wd[7:0]});
    if (!who) chk("stall_t1", {31'h0, cpu_stall}, 32'h1);
    @(negedge clk);
    chk("hi_addr", {19'h0, mem_addr}, {19'h0, ba | 13'h1});
    chk("hi_we", {31'h0, mem_we}, {31'h0, we});
    if (we) chk("hi_wd", {24'h0, mem_wd}, {24'h0, wd[15:8]});
    if (!who) chk("stall_t2", {31'h0, cpu_stall}, 32'h1);
    @(negedge clk);
    chk("resp_bus", {mem_we, mem_addr, mem_wd}, 32'h0);
    if (!who) chk("stall_t3", {31'h0, cpu_stall}, 32'h0);
    wait_all(10);
  endtask

  // Monitors: every done pulse pops its requester's queue and is compared.
  always @(negedge clk) begin
    sb_item_t it;
    if (cpu_done) begin
      if (cpu_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cpu_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        it = cpu_q.pop_front();
        chk("cpu_latency", cyc - it.t0, it.lat);
        if (it.ld) begin
          chk("cpu_rd", {16'h0, cpu_rd}, {16'h0, it.d});
          last_cpu_rd = it.d;
        end
        if (spacing_on && last_cpu_done >= 0) chk("cpu_spacing", cyc - last_cpu_done, 4);
        last_cpu_done = cyc;
      end
    end
    if (dbg_done) begin
      if (dbg_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL dbg_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        it = dbg_q.pop_front();
        chk("dbg_latency", cyc - it.t0, it.lat);
        if (it.ld) begin
          chk("dbg_rd", {16'h0, dbg_rd}, {16'h0, it.d});
          last_dbg_rd = it.d;
        end
      end
    end
    if (r_cpu_done || r_dbg_done) begin
      if (rr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL rr_done_unexpected actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        chk("rr_owner", {30'h0, r_dbg_done, r_cpu_done}, rr_q.pop_front() ? 32'h2 : 32'h1);
      end
    end
  end

  initial begin
    logic [15:0] a, wd, old;
    bit we;
    for (int i = 0; i < 8192; i++) bmem[i] = 8'h00;
    for (int i = 0; i < 4096; i++) ref_mem[i] = 16'h0000;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wd = 0;
    r_cpu_req = 0; r_dbg_req = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bus", {mem_we, mem_addr, mem_wd}, 32'h0);
    chk("rst_done", {30'h0, cpu_done, dbg_done}, 32'h0);
    chk("rst_rd", {cpu_rd, dbg_rd}, 32'h0);
    chk("rst_stall", {31'h0, cpu_stall}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Store then load back, then a wrapped dbg load at the top of the segment.
    access_check(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    access_check(1'b0, 1'b0, 16'h0010, 16'h0000);
    access_check(1'b1, 1'b1, 16'hFFFF, 16'h1234);
    access_check(1'b1, 1'b0, 16'hFFFF, 16'h0000);
    access_check(1'b1, 1'b0, 16'hF7FF, 16'h0000);
    access_check(1'b1, 1'b0, 16'h0010, 16'h0000);

    // Simultaneous requests, fixed priority: cpu first, dbg on the next grant.
    issue(1'b0, 1'b1, 16'h0020, 16'hA5C3, 3);
    issue(1'b1, 1'b0, 16'h0010, 16'h0000, 7);
    wait_all(20);
    access_check(1'b1, 1'b0, 16'h0020, 16'h0000);

    // Reset during the HI byte of a store: low byte already written, no done.
    a = 16'h0033; old = ref_mem[a[11:0]];
    issue(1'b0, 1'b1, a, 16'h7E81, 3);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mid_done", {31'h0, cpu_done}, 32'h0);
    cpu_req = 1'b0;
    cpu_q.delete();
    ref_mem[a[11:0]] = {old[15:8], 8'h81};
    last_cpu_rd = 16'h0; last_dbg_rd = 16'h0;
    @(posedge clk); #1;
    chk("rst_mid_rd", {cpu_rd, dbg_rd}, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access_check(1'b0, 1'b0, a, 16'h0000);

    // Continuous cpu traffic, random load/store mix over a small reused window.
    spacing_on = 1'b1; last_cpu_done = -1;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      a  = (16'($urandom_range(0, 7)) + 16'h0040) | (16'($urandom) & 16'hF000);
      wd = 16'($urandom);
      access_check(1'b0, we, a, wd);
    end
    spacing_on = 1'b0;

    // Round-robin instance: four ties must alternate starting with cpu.
    rr_q.push_back(1'b0); rr_q.push_back(1'b1);
    rr_q.push_back(1'b0); rr_q.push_back(1'b1);
    r_cpu_req = 1'b1; r_dbg_req = 1'b1;
    for (int k = 0; k < 40 && rr_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    r_cpu_req = 1'b0; r_dbg_req = 1'b0;
    chk("rr_pending", rr_q.size(), 0);

    repeat (8) @(posedge clk);
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("dbg_q_empty", dbg_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
